// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
// Contents: FSM state enum and the fixed word/block/address widths.
package cache_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int MEM_ADDR_W      = 28;
  localparam int PROC_ADDR_W     = 30;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Storage for the cache lines: valid, dirty, tag and 128-bit data per line.
// Ports:
//   clk, rst_n          clock, async active-low clear of every line
//   rd_idx              combinational read index
//   rd_valid/rd_dirty/rd_tag/rd_data   contents of line rd_idx
//   wr_en/wr_idx/wr_word/wr_data       single-word store, sets dirty
//   fill_en/fill_idx/fill_tag/fill_data  whole-block fill, sets valid,
//                                        clears dirty (wins over wr_en)
module cache_line_array
  import cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int TAG_W = 25,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [BLOCK_W-1:0]   rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [1:0]           wr_word,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 fill_en,
  input  logic [IDX_W-1:0]     fill_idx,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [BLOCK_W-1:0]   fill_data
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
      tag_q[fill_idx]   <= fill_tag;
      data_q[fill_idx]  <= fill_data;
    end else if (wr_en) begin
      dirty_q[wr_idx] <= 1'b1;
      data_q[wr_idx][{wr_word, 5'd0} +: WORD_W] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   proc_read/proc_write             core request (write wins), held while stalled
//   proc_addr[29:0]                  word address {tag, idx, word}
//   proc_wdata[31:0]                 store data
//   proc_stall                       request not yet complete (combinational)
//   proc_rdata[31:0]                 addressed word of the indexed line
//   mem_read/mem_write               block fetch / write-back request
//   mem_addr[27:0], mem_wdata[127:0] block address and evicted block
//   mem_rdata[127:0], mem_ready      fetched block and completion pulse
module dcache_direct_wb
  import cache_pkg::*;
#(
  parameter int LINES = 8,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = MEM_ADDR_W - IDX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    proc_read,
  input  logic                    proc_write,
  input  logic [PROC_ADDR_W-1:0]  proc_addr,
  input  logic [WORD_W-1:0]       proc_wdata,
  output logic                    proc_stall,
  output logic [WORD_W-1:0]       proc_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic [BLOCK_W-1:0]      mem_wdata,
  input  logic [BLOCK_W-1:0]      mem_rdata,
  input  logic                    mem_ready
);

  state_t state_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            word;
  logic                  req;
  logic                  hit;

  logic                  rd_valid;
  logic                  rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [BLOCK_W-1:0]    rd_data;

  logic [IDX_W-1:0]      miss_idx_q;
  logic [TAG_W-1:0]      miss_tag_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [BLOCK_W-1:0]    mem_wdata_q;

  logic                  wr_en;
  logic                  fill_en;

  assign word = proc_addr[1:0];
  assign idx  = proc_addr[IDX_W+1:2];
  assign tag  = proc_addr[PROC_ADDR_W-1:IDX_W+2];
  assign req  = proc_read | proc_write;
  assign hit  = rd_valid && (rd_tag == tag);

  assign proc_stall = req && ((state_q != IDLE) || !hit);
  assign proc_rdata = rd_data[{word, 5'd0} +: WORD_W];

  assign wr_en   = (state_q == IDLE) && proc_write && hit;
  assign fill_en = (state_q == ALLOCATE) && mem_ready;

  cache_line_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_idx    (idx),
    .wr_word   (word),
    .wr_data   (proc_wdata),
    .fill_en   (fill_en),
    .fill_idx  (miss_idx_q),
    .fill_tag  (miss_tag_q),
    .fill_data (mem_rdata)
  );

  // The missing address and the victim line are captured when the miss is
  // detected, so the memory-side outputs depend only on flops while a miss
  // is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      miss_idx_q  <= '0;
      miss_tag_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            miss_idx_q <= idx;
            miss_tag_q <= tag;
            if (rd_valid && rd_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {rd_tag, idx};
              mem_wdata_q <= rd_data;
            end else begin
              state_q    <= ALLOCATE;
              mem_read_q <= 1'b1;
              mem_addr_q <= {tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state_q     <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {miss_tag_q, miss_idx_q};
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb (LINES=8: idx=addr[4:2], tag=addr[29:5]).
module tb_dcache_direct_wb;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] BLK1 = 128'h44443333_22221111_DEADBEEF_00000000;
  localparam logic [127:0] BLK2 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] BLK3 = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
  localparam logic [127:0] BLK4 = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
  localparam logic [127:0] BLK5 = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
  localparam logic [127:0] BLK6 = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;

  dcache_direct_wb #(.LINES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory-side responder: waits (bounded) for the wanted request, records
  // its address/data, then returns mem_ready on the lat-th request cycle.
  task automatic mem_phase(input bit want_write, input int lat,
                           input logic [127:0] blk,
                           output bit seen, output logic [27:0] addr,
                           output logic [127:0] wdata, output int stall_cyc,
                           output bit other_seen);
    seen = 0; other_seen = 0; stall_cyc = 0; addr = '0; wdata = '0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (want_write ? mem_write : mem_read) seen = 1;
      else begin
        if (want_write ? mem_read : mem_write) other_seen = 1;
        tick();
      end
    end
    if (seen) begin
      addr  = mem_addr;
      wdata = mem_wdata;
      for (int k = 1; k <= lat; k++) begin
        if (want_write ? mem_read : mem_write) other_seen = 1;
        if (proc_stall) stall_cyc++;
        if (k == lat) begin
          mem_ready = 1'b1;
          mem_rdata = blk;
        end
        tick();
      end
      mem_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; proc_read = 0; proc_write = 0; proc_addr = '0;
    proc_wdata = '0; mem_rdata = '0; mem_ready = 0;
    #12;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", proc_stall); end
    total++; if (proc_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", proc_rdata); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
    total++; if (mem_addr !== 28'h0) begin bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    total++; if (mem_wdata !== 128'h0) begin bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_read;
    bit seen, oth; logic [27:0] a; logic [127:0] wd; int sc;
    proc_read = 1; proc_addr = 30'h5;
    #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL cold_stall_idle got %b want 1", proc_stall); end
    mem_phase(0, 3, BLK1, seen, a, wd, sc, oth);
    total++; if (!seen) begin bad++; $display("FAIL cold_mem_read got none want pulse"); end
    total++; if (a !== 28'h1) begin bad++; $display("FAIL cold_mem_addr got %h want 0000001", a); end
    total++; if (sc != 3) begin bad++; $display("FAIL cold_stall_cycles got %0d want 3", sc); end
    total++; if (oth) begin bad++; $display("FAIL cold_no_write got 1 want 0"); end
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL cold_stall_after got %b want 0", proc_stall); end
    total++; if (proc_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cold_rdata got %h want deadbeef", proc_rdata); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL cold_mem_read_drop got %b want 0", mem_read); end
  endtask

  task automatic test_write_hit;
    proc_read = 0; proc_write = 1; proc_addr = 30'h6; proc_wdata = 32'hCAFEF00D;
    #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL whit_stall got %b want 0", proc_stall); end
    tick();
    proc_write = 0; proc_read = 1; proc_addr = 30'h6;
    #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL whit_rd_stall got %b want 0", proc_stall); end
    total++; if (proc_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL whit_rdata got %h want cafef00d", proc_rdata); end
    proc_addr = 30'h5;
    #1;
    total++; if (proc_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL whit_neighbour got %h want deadbeef", proc_rdata); end
    // stray mem_ready with no request must be ignored
    proc_read = 0; mem_ready = 1; mem_rdata = BLK6;
    tick();
    mem_ready = 0;
    #1;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL idle_ready got rd=%b wr=%b want 0 0", mem_read, mem_write); end
    proc_read = 1; proc_addr = 30'h6;
    #1;
    total++; if (proc_rdata !== 32'hCAFEF00D || proc_stall !== 1'b0) begin bad++; $display("FAIL idle_ready_data got %h stall=%b want cafef00d 0", proc_rdata, proc_stall); end
  endtask

  task automatic test_dirty_evict;
    bit seen, oth; logic [27:0] a; logic [127:0] wd; int sc;
    proc_read = 1; proc_write = 0; proc_addr = 30'h26;
    #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL dirty_stall got %b want 1", proc_stall); end
    mem_phase(1, 2, 128'h0, seen, a, wd, sc, oth);
    total++; if (!seen) begin bad++; $display("FAIL dirty_wb got none want mem_write"); end
    total++; if (a !== 28'h1) begin bad++; $display("FAIL dirty_wb_addr got %h want 0000001", a); end
    total++; if (wd[95:64] !== 32'hCAFEF00D) begin bad++; $display("FAIL dirty_wb_w2 got %h want cafef00d", wd[95:64]); end
    total++; if (wd[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL dirty_wb_w1 got %h want deadbeef", wd[63:32]); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL dirty_wr_drop got %b want 0", mem_write); end
    mem_phase(0, 2, BLK2, seen, a, wd, sc, oth);
    total++; if (!seen || a !== 28'h9) begin bad++; $display("FAIL dirty_fill_addr got seen=%b %h want 1 0000009", seen, a); end
    total++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hA2A2A2A2) begin bad++; $display("FAIL dirty_rdata got %h stall=%b want a2a2a2a2 0", proc_rdata, proc_stall); end
  endtask

  task automatic test_clean_evict;
    bit seen, oth; logic [27:0] a; logic [127:0] wd; int sc;
    proc_read = 1; proc_addr = 30'h46;
    #1;
    mem_phase(0, 1, BLK3, seen, a, wd, sc, oth);
    total++; if (oth) begin bad++; $display("FAIL clean_no_wb got mem_write want none"); end
    total++; if (!seen || a !== 28'h11) begin bad++; $display("FAIL clean_addr got seen=%b %h want 1 0000011", seen, a); end
    total++; if (proc_stall !== 1'b0 || proc_rdata !== 32'hC2C2C2C2) begin bad++; $display("FAIL clean_rdata got %h stall=%b want c2c2c2c2 0", proc_rdata, proc_stall); end
  endtask

  task automatic test_write_miss;
    bit seen, oth; logic [27:0] a; logic [127:0] wd; int sc;
    proc_read = 0; proc_write = 1; proc_addr = 30'h0C; proc_wdata = 32'h12345678;
    #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL wmiss_stall got %b want 1", proc_stall); end
    mem_phase(0, 1, BLK4, seen, a, wd, sc, oth);
    total++; if (!seen || oth || a !== 28'h3) begin bad++; $display("FAIL wmiss_alloc got seen=%b wb=%b %h want 1 0 0000003", seen, oth, a); end
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL wmiss_hit_cycle got %b want 0", proc_stall); end
    tick();
    proc_write = 0; proc_read = 1;
    #1;
    total++; if (proc_rdata !== 32'h12345678) begin bad++; $display("FAIL wmiss_rdata got %h want 12345678", proc_rdata); end
    proc_addr = 30'h0D;
    #1;
    total++; if (proc_rdata !== 32'hD1D1D1D1) begin bad++; $display("FAIL wmiss_w1 got %h want d1d1d1d1", proc_rdata); end
    proc_addr = 30'h2C;
    #1;
    mem_phase(1, 1, 128'h0, seen, a, wd, sc, oth);
    total++; if (!seen || a !== 28'h3) begin bad++; $display("FAIL wmiss_wb_addr got seen=%b %h want 1 0000003", seen, a); end
    total++; if (wd !== 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_12345678) begin bad++; $display("FAIL wmiss_wb_data got %h want d3d3d3d3d2d2d2d2d1d1d1d112345678", wd); end
    mem_phase(0, 2, BLK5, seen, a, wd, sc, oth);
    total++; if (!seen || a !== 28'hB) begin bad++; $display("FAIL wmiss_refill got seen=%b %h want 1 000000b", seen, a); end
    total++; if (proc_rdata !== 32'hE0E0E0E0) begin bad++; $display("FAIL wmiss_refill_data got %h want e0e0e0e0", proc_rdata); end
  endtask

  task automatic test_alias_msb;
    bit seen, oth; logic [27:0] a; logic [127:0] wd; int sc;
    proc_read = 0; proc_write = 1; proc_addr = 30'h2C; proc_wdata = 32'hA5A5A5A5;
    #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL alias_whit got %b want 0", proc_stall); end
    tick();
    proc_write = 0; proc_read = 1; proc_addr = 30'h2000002C;
    #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL alias_miss got %b want 1", proc_stall); end
    mem_phase(1, 1, 128'h0, seen, a, wd, sc, oth);
    total++; if (!seen || a !== 28'hB || wd[31:0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL alias_wb got seen=%b %h %h want 1 000000b a5a5a5a5", seen, a, wd[31:0]); end
    mem_phase(0, 1, BLK6, seen, a, wd, sc, oth);
    total++; if (!seen || a !== 28'h800000B) begin bad++; $display("FAIL alias_fill got seen=%b %h want 1 800000b", seen, a); end
    total++; if (proc_rdata !== 32'hF0F0F0F0 || proc_stall !== 1'b0) begin bad++; $display("FAIL alias_rdata got %h stall=%b want f0f0f0f0 0", proc_rdata, proc_stall); end
  endtask

  task automatic test_reset_mid_alloc;
    bit seen;
    proc_read = 1; proc_addr = 30'h10;
    #1;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (mem_read) seen = 1;
      else tick();
    end
    total++; if (!seen || mem_addr !== 28'h4) begin bad++; $display("FAIL rst_alloc_req got seen=%b %h want 1 0000004", seen, mem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (mem_read !== 1'b0 || mem_addr !== 28'h0) begin bad++; $display("FAIL rst_mid_drop got rd=%b %h want 0 0", mem_read, mem_addr); end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL rst_remiss got %b want 1", proc_stall); end
    proc_addr = 30'h5;
    #1;
    total++; if (proc_stall !== 1'b1 || proc_rdata !== 32'h0) begin bad++; $display("FAIL rst_old_line got stall=%b %h want 1 0", proc_stall, proc_rdata); end
    proc_read = 0;
    tick();
    total++; if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin bad++; $display("FAIL rst_idle got rd=%b stall=%b want 0 0", mem_read, proc_stall); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_clean_evict();
    test_write_miss();
    test_alias_msb();
    test_reset_mid_alloc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
